prog_loader: RTL



---
 rtl/prog_loader.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// Streaming program loader: writes a valid/ready word stream into program memory,
// optionally zero-fills the remaining slots, and releases the CPU once the image is complete.
module prog_loader #(
    parameter int unsigned INSTR_SIZE   = 12,
    parameter int unsigned ADDR_SIZE    = 5,
    parameter int unsigned PROGRAM_SIZE = 16,
    parameter int unsigned CLEAR_REST   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INSTR_SIZE-1:0] in_data,
    input  logic                  in_last,
    output logic                  mem_we,
    output logic [ADDR_SIZE-1:0]  mem_addr,
    output logic [INSTR_SIZE-1:0] mem_wdata,
    output logic                  cpu_run,
    output logic                  busy,
    output logic                  done,
    output logic                  out_of_bounds,
    output logic [INSTR_SIZE-1:0] checksum,
    output logic [ADDR_SIZE:0]    word_count
);

    // One extra address bit so the address can sit at PROGRAM_SIZE without wrapping.
    localparam int unsigned AW = ADDR_SIZE + 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(PROGRAM_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FILL,
        S_DONE,
        S_ERROR
    } state_e;

    state_e                state_q, state_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [INSTR_SIZE-1:0] checksum_q, checksum_d;
    logic [AW-1:0]         count_q, count_d;
    logic                  done_q, done_d;
    logic                  oob_q, oob_d;
    logic                  run_q, run_d;
    logic                  drained_q, drained_d;
    logic                  beat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            checksum_q <= '0;
            count_q    <= '0;
            done_q     <= 1'b0;
            oob_q      <= 1'b0;
            run_q      <= 1'b0;
            drained_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            checksum_q <= checksum_d;
            count_q    <= count_d;
            done_q     <= done_d;
            oob_q      <= oob_d;
            run_q      <= run_d;
            drained_q  <= drained_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        checksum_d = checksum_q;
        count_d    = count_q;
        done_d     = done_q;
        oob_d      = oob_q;
        run_d      = run_q;
        drained_d  = drained_q;
        in_ready   = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        busy       = 1'b0;
        beat       = 1'b0;

        case (state_q)
            S_LOAD: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                beat     = in_valid;
                if (beat) begin
                    mem_we     = 1'b1;
                    mem_addr   = addr_q[ADDR_SIZE-1:0];
                    mem_wdata  = in_data;
                    checksum_d = checksum_q ^ in_data;
                    count_d    = count_q + AW'(1);
                    addr_d     = addr_q + AW'(1);
                    if (in_last) begin
                        if (CLEAR_REST == 0 || addr_q == LAST_ADDR) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            run_d   = 1'b1;
                        end else begin
                            state_d = S_FILL;
                        end
                    end else if (addr_q == LAST_ADDR) begin
                        state_d   = S_ERROR;
                        oob_d     = 1'b1;
                        drained_d = 1'b0;
                    end
                end
            end
            S_FILL: begin
                busy     = 1'b1;
                mem_we   = 1'b1;
                mem_addr = addr_q[ADDR_SIZE-1:0];
                addr_d   = addr_q + AW'(1);
                if (addr_q == LAST_ADDR) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    run_d   = 1'b1;
                end
            end
            S_IDLE, S_DONE, S_ERROR: begin
                // ERROR keeps accepting (and dropping) words until the image's last word.
                if (state_q == S_ERROR) begin
                    in_ready = ~drained_q;
                    beat     = in_valid & ~drained_q;
                    if (beat && in_last) begin
                        drained_d = 1'b1;
                    end
                end
                if (start) begin
                    state_d    = S_LOAD;
                    addr_d     = '0;
                    checksum_d = '0;
                    count_d    = '0;
                    done_d     = 1'b0;
                    oob_d      = 1'b0;
                    run_d      = 1'b0;
                    drained_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cpu_run       = run_q;
    assign done          = done_q;
    assign out_of_bounds = oob_q;
    assign checksum      = checksum_q;
    assign word_count    = count_q;

endmodule
